// File: rtl/wb_regfile_scoreboard_if.sv
// wb_regfile_scoreboard_if: write-back, decode read, reservation and status signals of the register file scoreboard.
interface wb_regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] wb_result;
    logic [ADDR_WIDTH-1:0] wb_reg_addr;
    logic                  wb_we;
    logic                  rd_en_a;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic                  rd_en_b;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  rsv_en;
    logic [ADDR_WIDTH-1:0] rsv_addr;
    logic                  stall;
    logic                  err_overflow;
    logic                  err_orphan;

    modport master (
        output wb_result, wb_reg_addr, wb_we,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, stall, err_overflow, err_orphan
    );

    modport slave (
        input  wb_result, wb_reg_addr, wb_we,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, stall, err_overflow, err_orphan
    );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: write-back register file with bypassed read ports and per-register pending-write RAW scoreboard.
module wb_regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 2
) (
    input logic clk,
    input logic reset,
    wb_regfile_scoreboard_if.slave bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [CNT_WIDTH-1:0]  cnt  [NREG];
    logic hit_a, hit_b, busy_a, busy_b;
    logic same, inc_only, dec_only;

    always_comb begin
        hit_a = bus.wb_we && bus.wb_reg_addr == bus.rd_addr_a;
        hit_b = bus.wb_we && bus.wb_reg_addr == bus.rd_addr_b;
        bus.rd_data_a = hit_a ? bus.wb_result : regs[bus.rd_addr_a];
        bus.rd_data_b = hit_b ? bus.wb_result : regs[bus.rd_addr_b];
        // a write-back landing now retires one of the pending writes it is checked against
        busy_a = cnt[bus.rd_addr_a] > CNT_WIDTH'(hit_a);
        busy_b = cnt[bus.rd_addr_b] > CNT_WIDTH'(hit_b);
        bus.stall = (bus.rd_en_a && busy_a) || (bus.rd_en_b && busy_b);
        same = bus.rsv_en && bus.wb_we && bus.rsv_addr == bus.wb_reg_addr;
        inc_only = bus.rsv_en && !same;
        dec_only = bus.wb_we && !same;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            bus.err_overflow <= 1'b0;
            bus.err_orphan   <= 1'b0;
        end else begin
            if (bus.wb_we)
                regs[bus.wb_reg_addr] <= bus.wb_result;
            // inc_only and dec_only can only both fire on different registers
            if (inc_only && cnt[bus.rsv_addr] != CNT_MAX)
                cnt[bus.rsv_addr] <= cnt[bus.rsv_addr] + CNT_WIDTH'(1);
            if (dec_only && cnt[bus.wb_reg_addr] != '0)
                cnt[bus.wb_reg_addr] <= cnt[bus.wb_reg_addr] - CNT_WIDTH'(1);
            bus.err_overflow <= bus.err_overflow || (inc_only && cnt[bus.rsv_addr] == CNT_MAX);
            bus.err_orphan   <= bus.err_orphan || (dec_only && cnt[bus.wb_reg_addr] == '0);
        end
    end
endmodule
